imem_program_encoder: RTL and testbench

//  Encoder counterpart of the instruction decoder: takes field-level instruction requests
//  (op class, registers, immediate/target) over a valid/ready stream and packs them into
//  32-bit MIPS words.

---
 rtl/imem_program_encoder_pkg.sv | 49 ++++
 rtl/imem_program_encoder_if.sv | 35 +++
 rtl/instr_field_packer.sv | 53 +++++
 rtl/imem_program_encoder.sv | 126 ++++++++++++
 tb/tb_imem_program_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_program_encoder_pkg.sv
// Shared MIPS ISA constants: opcodes, R-type functs, request op classes, loader states.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: OPC_* opcode fields, FN_* funct fields, IOP_* request op classes,
//           enc_state_e loader states, itype() I-format packing helper.
package imem_program_encoder_pkg;

   // primary opcode field, bits [31:26]
   localparam logic [5:0] OPC_R_FORMAT = 6'd0;
   localparam logic [5:0] OPC_J        = 6'd2;
   localparam logic [5:0] OPC_JAL      = 6'd3;
   localparam logic [5:0] OPC_BEQ      = 6'd4;
   localparam logic [5:0] OPC_ADDIU    = 6'd9;
   localparam logic [5:0] OPC_LW       = 6'd35;
   localparam logic [5:0] OPC_SW       = 6'd43;

   // R-type funct field, bits [5:0]
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2a;

   // request op classes on in_op; 8..15 are illegal
   localparam logic [3:0] IOP_NOP   = 4'd0;
   localparam logic [3:0] IOP_RTYPE = 4'd1;
   localparam logic [3:0] IOP_LW    = 4'd2;
   localparam logic [3:0] IOP_SW    = 4'd3;
   localparam logic [3:0] IOP_BEQ   = 4'd4;
   localparam logic [3:0] IOP_J     = 4'd5;
   localparam logic [3:0] IOP_ADDIU = 4'd6;
   localparam logic [3:0] IOP_JAL   = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_PAD    = 2'd2,
      ST_DONE   = 2'd3
   } enc_state_e;

   function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/imem_program_encoder_if.sv
// Request stream (valid/ready) plus instruction-memory write port of the program loader.
// Latency: none (wiring only).
// Backpressure: in_ready gates the request stream; the write port cannot be stalled.
// slave : encoder side (takes requests, drives the write port)
// master: request source / memory side
interface imem_program_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [5:0]        in_funct;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              in_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport slave (
      input  in_valid, in_op, in_funct, in_rs, in_rt, in_rd, in_shamt,
             in_imm, in_target, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport master (
      output in_valid, in_op, in_funct, in_rs, in_rt, in_rd, in_shamt,
             in_imm, in_target, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/instr_field_packer.sv
// Packs field-level instruction requests into 32-bit MIPS words; flags illegal op classes.
// Latency: combinational.
// Backpressure: none.
// Ports: op/funct/rs/rt/rd/shamt/imm/target in -> word (32b), illegal (op 8..15, word is 0).
module instr_field_packer
   import imem_program_encoder_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [5:0]  funct,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   logic [4:0] rs_f;
   logic [4:0] rt_f;
   logic [4:0] sh_f;

   always_comb begin
      word    = 32'd0;
      illegal = 1'b0;
      rs_f    = rs;
      rt_f    = rt;
      sh_f    = shamt;
      case (op)
         IOP_NOP:   word = 32'd0;
         IOP_RTYPE: begin
            // srl has no rs operand; mfhi/mflo read only hi/lo
            if (funct == FN_SRL)
               rs_f = 5'd0;
            if ((funct == FN_MFHI) || (funct == FN_MFLO)) begin
               rs_f = 5'd0;
               rt_f = 5'd0;
               sh_f = 5'd0;
            end
            word = {OPC_R_FORMAT, rs_f, rt_f, rd, sh_f, funct};
         end
         IOP_LW:    word = itype(OPC_LW, rs, rt, imm);
         IOP_SW:    word = itype(OPC_SW, rs, rt, imm);
         IOP_BEQ:   word = itype(OPC_BEQ, rs, rt, imm);
         IOP_ADDIU: word = itype(OPC_ADDIU, rs, rt, imm);
         IOP_J:     word = {OPC_J, target};
         IOP_JAL:   word = {OPC_JAL, target};
         default:   illegal = 1'b1;  // slot still written, as a NOP
      endcase
   end

endmodule

// File: rtl/imem_program_encoder.sv
// Program loader: encodes requests into MIPS words, writes them to imem, then pads NOPs.
// Latency: request accepted in cycle N -> wr_en with registered addr/data in cycle N+1.
// Backpressure: in_ready is high only while encoding; the write port is never stalled.
// Ports: clk, rst (async, high), start pulse, bus (requests in / imem writes out),
//        busy (ENCODE or PAD), done (level), err (sticky per session), count (words written).
module imem_program_encoder
   import imem_program_encoder_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0,
   parameter int PAD_NOPS   = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   imem_program_encoder_if.slave   bus,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDR_W:0]         count
);

   localparam int PAD_W = (PAD_NOPS > 1) ? $clog2(PAD_NOPS + 1) : 1;

   enc_state_e        state;
   enc_state_e        state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [PAD_W-1:0]  pad_left;
   logic              accept;
   logic              pad_wr;
   logic              do_wr;
   logic              at_top;
   logic              can_start;
   logic [31:0]       packed_word;
   logic              op_illegal;

   instr_field_packer u_packer (
      .op      (bus.in_op),
      .funct   (bus.in_funct),
      .rs      (bus.in_rs),
      .rt      (bus.in_rt),
      .rd      (bus.in_rd),
      .shamt   (bus.in_shamt),
      .imm     (bus.in_imm),
      .target  (bus.in_target),
      .word    (packed_word),
      .illegal (op_illegal)
   );

   // ready depends on state only, so a source may wait on it before raising valid
   assign bus.in_ready = (state == ST_ENCODE);
   assign busy         = (state == ST_ENCODE) || (state == ST_PAD);
   assign done         = (state == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      pad_wr    = 1'b0;
      can_start = 1'b0;
      do_wr     = 1'b0;
      at_top    = (ptr == {ADDR_W{1'b1}});
      case (state)
         ST_IDLE, ST_DONE: begin
            can_start = start;
            if (start)
               state_nxt = ST_ENCODE;
         end
         ST_ENCODE: begin
            accept = bus.in_valid;
            if (accept) begin
               // the top word is the last one that fits: session ends there
               if (at_top)
                  state_nxt = ST_DONE;
               else if (bus.in_last)
                  state_nxt = (PAD_NOPS == 0) ? ST_DONE : ST_PAD;
            end
         end
         ST_PAD: begin
            pad_wr = 1'b1;
            if (at_top || (pad_left == PAD_W'(1)))
               state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      do_wr = accept | pad_wr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= '0;
         count       <= '0;
         err         <= 1'b0;
         pad_left    <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= 32'd0;
      end else begin
         bus.wr_en <= do_wr;
         if (can_start) begin
            ptr   <= ADDR_W'(START_ADDR);
            count <= '0;
            err   <= 1'b0;
         end
         if (do_wr) begin
            bus.wr_addr <= ptr;
            bus.wr_data <= accept ? packed_word : 32'd0;
            ptr         <= ptr + 1'b1;
            count       <= count + 1'b1;
            if (at_top || (accept && op_illegal))
               err <= 1'b1;
         end
         if (accept && bus.in_last)
            pad_left <= PAD_W'(PAD_NOPS);
         else if (pad_wr)
            pad_left <= pad_left - 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Bench: two loaders (8-bit addr / 4 pads, 2-bit addr / no pads) on a shared request stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_program_encoder;

   localparam int AW0 = 8;
   localparam int AW1 = 2;
   localparam int PN0 = 4;
   localparam int PN1 = 0;
   localparam int P_IDLE = 0, P_LOAD = 1, P_PAD = 2, P_DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0;
   logic [3:0]  in_op = '0;
   logic [5:0]  in_funct = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;

   logic busy0, done0, err0, busy1, done1, err1;
   logic [AW0:0] count0;
   logic [AW1:0] count1;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   imem_program_encoder_if #(.ADDR_W(AW0)) bus0 ();
   imem_program_encoder_if #(.ADDR_W(AW1)) bus1 ();

   assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
   assign bus0.in_op = in_op;         assign bus1.in_op = in_op;
   assign bus0.in_funct = in_funct;   assign bus1.in_funct = in_funct;
   assign bus0.in_rs = in_rs;         assign bus1.in_rs = in_rs;
   assign bus0.in_rt = in_rt;         assign bus1.in_rt = in_rt;
   assign bus0.in_rd = in_rd;         assign bus1.in_rd = in_rd;
   assign bus0.in_shamt = in_shamt;   assign bus1.in_shamt = in_shamt;
   assign bus0.in_imm = in_imm;       assign bus1.in_imm = in_imm;
   assign bus0.in_target = in_target; assign bus1.in_target = in_target;
   assign bus0.in_last = in_last;     assign bus1.in_last = in_last;

   imem_program_encoder #(.ADDR_W(AW0), .START_ADDR(0), .PAD_NOPS(PN0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .bus(bus0),
      .busy(busy0), .done(done0), .err(err0), .count(count0));

   imem_program_encoder #(.ADDR_W(AW1), .START_ADDR(0), .PAD_NOPS(PN1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .bus(bus1),
      .busy(busy1), .done(done1), .err(err1), .count(count1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      else
         n_pass++;
   endtask

   // Reference encoding from the instruction-format field positions.
   function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [5:0] fn,
         input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
         input logic [4:0] sh_i, input logic [15:0] im, input logic [25:0] tg,
         output bit legal);
      longint rs, rt, rd, sh, f, opc, w;
      rs = rs_i; rt = rt_i; rd = rd_i; sh = sh_i; f = fn;
      legal = (op < 8);
      w = 0;
      case (op)
         4'd1: begin
            if (f == 2) rs = 0;
            if (f == 16 || f == 18) begin rs = 0; rt = 0; sh = 0; end
            w = rs * (1 << 21) + rt * (1 << 16) + rd * 2048 + sh * 64 + f;
         end
         4'd2, 4'd3, 4'd4, 4'd6: begin
            opc = (op == 2) ? 35 : (op == 3) ? 43 : (op == 4) ? 4 : 9;
            w = opc * (1 << 26) + rs * (1 << 21) + rt * 65536 + longint'(im);
         end
         4'd5, 4'd7: w = ((op == 5) ? 2 : 3) * (1 << 26) + longint'(tg);
         default: w = 0;
      endcase
      return 32'(w);
   endfunction

   // ---------------- behavioural model (per loader) ----------------
   int          m_phase[2] = '{P_IDLE, P_IDLE};
   int          m_ptr[2]   = '{0, 0};
   int          m_cnt[2]   = '{0, 0};
   int          m_padl[2]  = '{0, 0};
   bit          m_err[2]   = '{0, 0};
   bit          e_wen[2]   = '{0, 0};
   int          e_addr[2]  = '{0, 0};
   logic [31:0] e_data[2]  = '{32'd0, 32'd0};

   always @(posedge clk or posedge rst) begin : model
      logic [31:0] w;
      bit lg, top;
      int sz, pn;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_ptr[i] = 0; m_cnt[i] = 0; m_padl[i] = 0;
            m_err[i] = 0; e_wen[i] = 0; e_addr[i] = 0; e_data[i] = 0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            sz = (i == 0) ? (1 << AW0) : (1 << AW1);
            pn = (i == 0) ? PN0 : PN1;
            e_wen[i] = 0;
            top = (m_ptr[i] == sz - 1);
            if (m_phase[i] == P_IDLE || m_phase[i] == P_DONE) begin
               if (start) begin
                  m_phase[i] = P_LOAD; m_ptr[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
               end
            end else if (m_phase[i] == P_LOAD || m_phase[i] == P_PAD) begin
               if (m_phase[i] == P_PAD || in_valid) begin
                  lg = 1;
                  w = 32'd0;
                  if (m_phase[i] == P_LOAD)
                     w = ref_encode(in_op, in_funct, in_rs, in_rt, in_rd, in_shamt,
                                    in_imm, in_target, lg);
                  if (!lg) m_err[i] = 1;
                  e_wen[i] = 1; e_addr[i] = m_ptr[i]; e_data[i] = w;
                  m_cnt[i]++; m_ptr[i] = (m_ptr[i] + 1) % sz;
                  if (m_phase[i] == P_PAD) m_padl[i]--;
                  if (top) begin
                     m_err[i] = 1; m_phase[i] = P_DONE;
                  end else if (m_phase[i] == P_LOAD) begin
                     if (in_last) begin
                        m_padl[i] = pn;
                        m_phase[i] = (pn > 0) ? P_PAD : P_DONE;
                     end
                  end else if (m_padl[i] == 0) begin
                     m_phase[i] = P_DONE;
                  end
               end
            end
         end
      end
   end

   task automatic cmp(input int i, input logic wen, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy, input logic bsy,
                      input logic dn, input logic er, input logic [31:0] cnt);
      chk($sformatf("d%0d.wr_en", i), wen, e_wen[i]);
      chk($sformatf("d%0d.wr_addr", i), addr, 32'(e_addr[i]));
      chk($sformatf("d%0d.wr_data", i), data, e_data[i]);
      chk($sformatf("d%0d.in_ready", i), rdy, m_phase[i] == P_LOAD);
      chk($sformatf("d%0d.busy", i), bsy, m_phase[i] == P_LOAD || m_phase[i] == P_PAD);
      chk($sformatf("d%0d.done", i), dn, m_phase[i] == P_DONE);
      chk($sformatf("d%0d.err", i), er, m_err[i]);
      chk($sformatf("d%0d.count", i), cnt, 32'(m_cnt[i]));
   endtask

   always @(negedge clk) begin
      cmp(0, bus0.wr_en, 32'(bus0.wr_addr), bus0.wr_data, bus0.in_ready,
          busy0, done0, err0, 32'(count0));
      cmp(1, bus1.wr_en, 32'(bus1.wr_addr), bus1.wr_data, bus1.in_ready,
          busy1, done1, err1, 32'(count1));
   end

   // ---------------- write log for the directed literal checks ----------------
   logic [31:0] la_a[2][1024];
   logic [31:0] la_d[2][1024];
   int          la_c[2][1024];
   int          ln[2] = '{0, 0};

   always @(negedge clk) begin
      if (bus0.wr_en) begin
         la_a[0][ln[0] % 1024] = 32'(bus0.wr_addr); la_d[0][ln[0] % 1024] = bus0.wr_data;
         la_c[0][ln[0] % 1024] = cyc; ln[0]++;
      end
      if (bus1.wr_en) begin
         la_a[1][ln[1] % 1024] = 32'(bus1.wr_addr); la_d[1][ln[1] % 1024] = bus1.wr_data;
         la_c[1][ln[1] % 1024] = cyc; ln[1]++;
      end
   end

   task automatic chk_log(input string nm, input int i, input int idx,
                          input logic [31:0] addr, input logic [31:0] data);
      chk({nm, ".addr"}, la_a[i][idx % 1024], addr);
      chk({nm, ".data"}, la_d[i][idx % 1024], data);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 0; in_last = 0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic send(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                       input logic [15:0] im, input logic [25:0] tg, input logic lst);
      in_op = op; in_funct = fn; in_rs = s; in_rt = t; in_rd = d; in_shamt = sh;
      in_imm = im; in_target = tg; in_last = lst; in_valid = 1;
      tick();
   endtask

   initial begin : main
      int b, b1;
      bit lg;
      tick(); tick();
      chk("reset.wr_en", bus0.wr_en, 0);
      chk("reset.done", done0, 0);
      chk("reset.count", count0, 0);
      rst = 0;
      tick();
      chk("model.addiu", ref_encode(4'd6, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, lg),
          32'h24080005);

      // T1: single ADDIU then four pad NOPs
      b = ln[0];
      pulse_start();
      send(4'd6, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1);
      idle(8);
      chk("t1.nwrites", ln[0] - b, 5);
      chk_log("t1.w0", 0, b, 0, 32'h24080005);
      for (int k = 1; k <= 4; k++) chk_log($sformatf("t1.pad%0d", k), 0, b + k, k, 0);
      chk("t1.done", done0, 1);
      chk("t1.count", count0, 5);

      // T2: LW, BEQ, srl back to back
      b = ln[0];
      pulse_start();
      send(4'd2, 6'd0, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 0);
      send(4'd4, 6'd0, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'd0, 0);
      send(4'd1, 6'h02, 5'd7, 5'd8, 5'd9, 5'd2, 16'd0, 26'd0, 1);
      idle(8);
      chk_log("t2.lw", 0, b, 0, 32'h8FA80004);
      chk_log("t2.beq", 0, b + 1, 1, 32'h1109FFFF);
      chk_log("t2.srl", 0, b + 2, 2, 32'h00084882);
      chk("t2.consec01", la_c[0][(b + 1) % 1024] - la_c[0][b % 1024], 1);
      chk("t2.consec12", la_c[0][(b + 2) % 1024] - la_c[0][(b + 1) % 1024], 1);

      // T3: J, JAL, MFHI
      b = ln[0];
      pulse_start();
      send(4'd5, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 0);
      send(4'd7, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 0);
      send(4'd1, 6'h10, 5'd5, 5'd0, 5'd3, 5'd0, 16'd0, 26'd0, 1);
      idle(8);
      chk_log("t3.j", 0, b, 0, 32'h08000010);
      chk_log("t3.jal", 0, b + 1, 1, 32'h0C000010);
      chk_log("t3.mfhi", 0, b + 2, 2, 32'h00001810);

      // T4: illegal op mid-stream keeps its slot
      b = ln[0];
      pulse_start();
      send(4'd6, 6'd0, 5'd0, 5'd1, 5'd0, 5'd0, 16'd1, 26'd0, 0);
      send(4'hF, 6'h3f, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 0);
      send(4'd6, 6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 16'd2, 26'd0, 1);
      idle(8);
      chk_log("t4.w0", 0, b, 0, 32'h24010001);
      chk_log("t4.illegal", 0, b + 1, 1, 32'h0);
      chk_log("t4.w2", 0, b + 2, 2, 32'h24020002);
      chk("t4.err", err0, 1);

      // T5: 2-bit address loader wraps after four words
      b1 = ln[1];
      pulse_start();
      for (int k = 1; k <= 6; k++)
         send(4'd6, 6'd0, 5'd0, 5'(k), 5'd0, 5'd0, 16'(k), 26'd0, k == 6);
      idle(6);
      chk("t5.nwrites", ln[1] - b1, 4);
      for (int k = 0; k < 4; k++)
         chk_log($sformatf("t5.w%0d", k), 1, b1 + k, k, 32'h24000000 + ((k + 1) << 16) + k + 1);
      chk("t5.err", err1, 1);
      chk("t5.done", done1, 1);
      chk("t5.count", count1, 4);
      chk("t5.in_ready", bus1.in_ready, 0);

      // T6: reset during PAD, with start held alongside reset
      pulse_start();
      send(4'hF, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
      send(4'd6, 6'd0, 5'd0, 5'd1, 5'd0, 5'd0, 16'd1, 26'd0, 1);
      idle(1);
      chk("t6.in_pad", busy0, 1);
      rst = 1; start = 1;
      #1;
      chk("t6.rst.wr_en", bus0.wr_en, 0);
      chk("t6.rst.wr_data", bus0.wr_data, 0);
      chk("t6.rst.busy", busy0, 0);
      chk("t6.rst.err", err0, 0);
      chk("t6.rst.count", count0, 0);
      tick();
      rst = 0; start = 0;
      tick();
      chk("t6.rst_wins", busy0, 0);
      b = ln[0];
      pulse_start();
      send(4'd6, 6'd0, 5'd0, 5'd3, 5'd0, 5'd0, 16'd3, 26'd0, 1);
      idle(1);
      chk_log("t6.restart", 0, b, 0, 32'h24030003);
      chk("t6.err_clear", err0, 0);
      idle(6);

      // randomized sessions, including start while busy and occasional reset
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom % 400) == 0;
         start = ($urandom % 10) == 0;
         in_valid = ($urandom % 4) != 0;
         in_op = (($urandom % 8) == 0) ? 4'(8 + $urandom % 8) : 4'($urandom % 8);
         case ($urandom % 5)
            0: in_funct = 6'h02;
            1: in_funct = 6'h10;
            2: in_funct = 6'h12;
            default: in_funct = 6'($urandom);
         endcase
         in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
         in_shamt = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
         in_last = ($urandom % 5) == 0;
         tick();
      end
      rst = 0; start = 0;
      idle(4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
